// File: rtl/conv_sched_pkg.sv
// rtl/conv_sched_pkg.sv - shared sizes and state encoding for the filter-bank convolution scheduler
package conv_sched_pkg;

  // Job geometry: N-sample x vector, M taps per filter, F filters in the ROM bank
  localparam int N = 32;
  localparam int M = 8;
  localparam int F = 4;
  localparam int L = N - M + 1;

  // Counter / address widths
  localparam int XW  = $clog2(N);
  localparam int KW  = $clog2(M);
  localparam int FW  = $clog2(F);
  localparam int LW  = $clog2(L);
  localparam int LCW = $clog2(N) + 1;

  // Address -> memory data -> product register: products lag addresses by this many cycles
  localparam int PIPE_D = 2;

  // State encoding
  typedef logic [2:0] state_t;
  localparam state_t S_INIT  = 3'd0;
  localparam state_t S_LOAD  = 3'd1;
  localparam state_t S_ISSUE = 3'd2;
  localparam state_t S_DRAIN = 3'd3;
  localparam state_t S_OUT   = 3'd4;

endpackage

// File: rtl/conv_sched_vdelay.sv
// rtl/conv_sched_vdelay.sv - D-stage valid delay line for MAC controllers
module conv_sched_vdelay #(
  parameter int D = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic vld,
  output logic vld_dly
);

  logic [D-1:0] pipe;

  // Shift the valid bit one stage per cycle; stage 0 samples the fresh input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= vld;
      for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign vld_dly = pipe[D-1];

endmodule

// File: rtl/conv_filter_bank_sched.sv
// rtl/conv_filter_bank_sched.sv - schedules one MAC datapath across a bank of F filters
module conv_filter_bank_sched
  import conv_sched_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          x_valid,
  output logic          x_ready,
  input  logic          y_ready,
  output logic          y_valid,
  output logic [FW-1:0] y_fsel,
  output logic [LW-1:0] y_idx,
  output logic          y_last,
  output logic [XW-1:0] addr_x,
  output logic          wr_en_x,
  output logic [FW-1:0] f_sel,
  output logic [KW-1:0] addr_f,
  output logic          clear_acc,
  output logic          en_acc
);

  state_t         state;
  logic [LCW-1:0] load_cnt;
  logic [KW-1:0]  k;      // tap index in ISSUE, drain cycle count in DRAIN
  logic [LW-1:0]  n;
  logic [FW-1:0]  f;

  logic load_open;
  logic issue_vld;
  logic at_last_n;
  logic at_last_f;

  assign load_open = (state == S_LOAD) && (load_cnt < LCW'(N));
  assign issue_vld = (state == S_ISSUE);
  assign at_last_n = (n == LW'(L - 1));
  assign at_last_f = (f == FW'(F - 1));

  // Accumulate enable is the issue window delayed to line up with the product register
  conv_sched_vdelay #(.D(PIPE_D)) u_vdelay (
    .clk     (clk),
    .reset   (reset),
    .vld     (issue_vld),
    .vld_dly (en_acc)
  );

  // Sequencer: load x once, then walk (f, n) filter-major, M taps per output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_INIT;
      load_cnt <= '0;
      k        <= '0;
      n        <= '0;
      f        <= '0;
    end else begin
      case (state)
        S_INIT: state <= S_LOAD;
        S_LOAD: begin
          if (x_valid && load_open) begin
            load_cnt <= load_cnt + 1'b1;
            if (load_cnt == LCW'(N - 1)) state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (k == KW'(M - 1)) begin
            k     <= '0;
            state <= S_DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DRAIN: begin
          if (k == KW'(PIPE_D - 1)) begin
            k     <= '0;
            state <= S_OUT;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_OUT: begin
          if (y_ready) begin
            if (at_last_n) begin
              n <= '0;
              if (at_last_f) begin
                f        <= '0;
                load_cnt <= '0;
                state    <= S_LOAD;
              end else begin
                f     <= f + 1'b1;
                state <= S_ISSUE;
              end
            end else begin
              n     <= n + 1'b1;
              state <= S_ISSUE;
            end
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // Per-state output decode; everything idles at zero outside its own state
  always_comb begin
    x_ready   = 1'b0;
    wr_en_x   = 1'b0;
    addr_x    = '0;
    f_sel     = '0;
    addr_f    = '0;
    clear_acc = 1'b0;
    y_valid   = 1'b0;
    y_fsel    = '0;
    y_idx     = '0;
    y_last    = 1'b0;
    case (state)
      S_LOAD: begin
        x_ready = load_open;
        wr_en_x = load_open;
        addr_x  = load_cnt[XW-1:0];
      end
      S_ISSUE: begin
        addr_x    = XW'(n) + XW'(k);
        addr_f    = k;
        f_sel     = f;
        clear_acc = (k == '0);
      end
      S_OUT: begin
        y_valid = 1'b1;
        y_fsel  = f;
        y_idx   = n;
        y_last  = at_last_n && at_last_f;
      end
      default: ;
    endcase
  end

endmodule
